// File: rtl/caravel_sram_scan_pkg.sv
// Shared definitions for the SRAM scan chain: the scan-word layout, field positions,
// bank-select codes and small decode helpers.
package caravel_sram_scan_pkg;

  localparam int SCAN_W = 112;

  localparam int SEL_MSB    = 111;
  localparam int SEL_LSB    = 108;
  localparam int ADDR0_MSB  = 107;
  localparam int ADDR0_LSB  = 92;
  localparam int DIN0_MSB   = 91;
  localparam int DIN0_LSB   = 60;
  localparam int CSB0_BIT   = 59;
  localparam int WEB0_BIT   = 58;
  localparam int WMASK0_MSB = 57;
  localparam int WMASK0_LSB = 54;
  localparam int ADDR1_MSB  = 53;
  localparam int ADDR1_LSB  = 38;
  localparam int DIN1_MSB   = 37;
  localparam int DIN1_LSB   = 6;
  localparam int CSB1_BIT   = 5;
  localparam int WEB1_BIT   = 4;
  localparam int WMASK1_MSB = 3;
  localparam int WMASK1_LSB = 0;

  localparam logic [3:0] DP_FIRST = 4'd0;
  localparam logic [3:0] DP_LAST  = 4'd4;
  localparam logic [3:0] SP_FIRST = 4'd8;
  localparam logic [3:0] SP_LAST  = 4'd11;
  localparam int         NUM_DP   = 5;
  localparam int         NUM_SP   = 4;

  // Unmapped code used to mean "no bank read yet", so dout decodes to zero.
  localparam logic [3:0] SEL_NONE = 4'hF;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr0;
    logic [31:0] din0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [15:0] addr1;
    logic [31:0] din1;
    logic        csb1;
    logic        web1;
    logic [3:0]  wmask1;
  } scan_word_t;

  function automatic logic is_sp(input logic [3:0] sel);
    return (sel >= SP_FIRST) && (sel <= SP_LAST);
  endfunction

endpackage

// File: rtl/caravel_sram_scan_sram_bank.sv
// One 32-bit RAM bank with byte-masked writes and registered reads; port 1 exists
// only when DUAL_PORT is set. Contents are never reset, only the read registers.
module sram_bank #(
  parameter int DEPTH     = 16,
  parameter int DUAL_PORT = 1,
  parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rd0_i,
  input  logic          wr0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [31:0]   din0_i,
  input  logic [3:0]    wmask0_i,
  output logic [31:0]   rdata0_o,
  input  logic          rd1_i,
  input  logic          wr1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [31:0]   din1_i,
  input  logic [3:0]    wmask1_i,
  output logic [31:0]   rdata1_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata0_q, rdata1_q;

  // Port 0 is written last so it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if ((DUAL_PORT != 0) && wr1_i && wmask1_i[k])
        mem_q[addr1_i][8*k +: 8] <= din1_i[8*k +: 8];
      if (wr0_i && wmask0_i[k])
        mem_q[addr0_i][8*k +: 8] <= din0_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rd0_i)
        rdata0_q <= mem_q[addr0_i];
      if ((DUAL_PORT != 0) && rd1_i)
        rdata1_q <= mem_q[addr1_i];
    end
  end

  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: rtl/caravel_sram_scan.sv
// Scan-chain front end for a set of SRAM banks: a 112-bit shift register carries one
// dual-port command, global_csb executes it and sram_load captures read data back.
module caravel_sram_scan #(
  parameter int DEPTH  = 16,
  parameter int SCAN_W = 112
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic in_select,
  input  logic scan_in,
  input  logic scan_en,
  input  logic sram_load,
  input  logic global_csb,
  output logic scan_out
);

  import caravel_sram_scan_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  scan_word_t  sr_q, sr_d;
  logic        rdValid0_q, rdValid0_d, rdValid1_q, rdValid1_d;
  logic [3:0]  rdSel0_q, rdSel0_d, rdSel1_q, rdSel1_d;
  logic        shiftLive, loadLive, opLive;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] dout0, dout1;
  logic [31:0] dpRdata0 [NUM_DP];
  logic [31:0] dpRdata1 [NUM_DP];
  logic [31:0] spRdata0 [NUM_SP];
  logic [31:0] spRdata1 [NUM_SP];

  assign shiftLive = in_select & scan_en;
  assign loadLive  = in_select & sram_load;
  assign opLive    = in_select & ~global_csb;

  // A cleared scan word has zero write masks and web=0, so it is a no-op during reset.
  assign rd0 = opLive & ~sr_q.csb0 &  sr_q.web0;
  assign wr0 = opLive & ~sr_q.csb0 & ~sr_q.web0;
  assign rd1 = opLive & ~sr_q.csb1 &  sr_q.web1 & ~is_sp(sr_q.sel);
  assign wr1 = opLive & ~sr_q.csb1 & ~sr_q.web1;

  for (genvar i = 0; i < NUM_DP; i++) begin : g_dp
    logic hit;
    assign hit = (sr_q.sel == (DP_FIRST + 4'(i)));
    sram_bank #(.DEPTH(DEPTH), .DUAL_PORT(1), .AW(AW)) u_bank (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .rd0_i    (rd0 & hit),
      .wr0_i    (wr0 & hit),
      .addr0_i  (sr_q.addr0[AW-1:0]),
      .din0_i   (sr_q.din0),
      .wmask0_i (sr_q.wmask0),
      .rdata0_o (dpRdata0[i]),
      .rd1_i    (rd1 & hit),
      .wr1_i    (wr1 & hit),
      .addr1_i  (sr_q.addr1[AW-1:0]),
      .din1_i   (sr_q.din1),
      .wmask1_i (sr_q.wmask1),
      .rdata1_o (dpRdata1[i])
    );
  end

  for (genvar i = 0; i < NUM_SP; i++) begin : g_sp
    logic hit;
    assign hit = (sr_q.sel == (SP_FIRST + 4'(i)));
    sram_bank #(.DEPTH(DEPTH), .DUAL_PORT(0), .AW(AW)) u_bank (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .rd0_i    (rd0 & hit),
      .wr0_i    (wr0 & hit),
      .addr0_i  (sr_q.addr0[AW-1:0]),
      .din0_i   (sr_q.din0),
      .wmask0_i (sr_q.wmask0),
      .rdata0_o (spRdata0[i]),
      .rd1_i    (1'b0),
      .wr1_i    (1'b0),
      .addr1_i  (sr_q.addr1[AW-1:0]),
      .din1_i   (sr_q.din1),
      .wmask1_i (sr_q.wmask1),
      .rdata1_o (spRdata1[i])
    );
  end

  // dout follows whichever bank each port last read; unmapped codes read as zero.
  always_comb begin
    dout0 = '0;
    dout1 = '0;
    for (int i = 0; i < NUM_DP; i++) begin
      if (rdSel0_q == (DP_FIRST + 4'(i))) dout0 = dpRdata0[i];
      if (rdSel1_q == (DP_FIRST + 4'(i))) dout1 = dpRdata1[i];
    end
    for (int i = 0; i < NUM_SP; i++) begin
      if (rdSel0_q == (SP_FIRST + 4'(i))) dout0 = spRdata0[i];
      if (rdSel1_q == (SP_FIRST + 4'(i))) dout1 = spRdata1[i];
    end
  end

  always_comb begin
    sr_d       = sr_q;
    rdValid0_d = rdValid0_q;
    rdValid1_d = rdValid1_q;
    rdSel0_d   = rdSel0_q;
    rdSel1_d   = rdSel1_q;
    if (loadLive) begin
      if (rdValid0_q) sr_d.din0 = dout0;
      if (rdValid1_q) sr_d.din1 = dout1;
      rdValid0_d = 1'b0;
      rdValid1_d = 1'b0;
    end else if (shiftLive) begin
      sr_d = {sr_q[SCAN_W-2:0], scan_in};
    end
    if (rd0) begin
      rdValid0_d = 1'b1;
      rdSel0_d   = sr_q.sel;
    end
    if (rd1) begin
      rdValid1_d = 1'b1;
      rdSel1_d   = sr_q.sel;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sr_q       <= '0;
      rdValid0_q <= 1'b0;
      rdValid1_q <= 1'b0;
      rdSel0_q   <= SEL_NONE;
      rdSel1_q   <= SEL_NONE;
    end else begin
      sr_q       <= sr_d;
      rdValid0_q <= rdValid0_d;
      rdValid1_q <= rdValid1_d;
      rdSel0_q   <= rdSel0_d;
      rdSel1_q   <= rdSel1_d;
    end
  end

  assign scan_out = sr_q[SCAN_W-1];

endmodule

// File: tb/tb_caravel_sram_scan.sv
// Directed bench for caravel_sram_scan: scans commands in, fires them, loads read
// data and scans the whole word back out against hand-built expected words.
module tb_caravel_sram_scan;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i, in_select, scan_in, scan_en, sram_load, global_csb;
  logic scan_out;

  int checks = 0;
  int errors = 0;

  logic [111:0] cmd, obs, exp;

  always #5 wb_clk_i = ~wb_clk_i;

  caravel_sram_scan #(.DEPTH(16), .SCAN_W(112)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .in_select  (in_select),
    .scan_in    (scan_in),
    .scan_en    (scan_en),
    .sram_load  (sram_load),
    .global_csb (global_csb),
    .scan_out   (scan_out)
  );

  function automatic logic [111:0] mk(
    input logic [3:0] sel, input logic [15:0] a0, input logic [31:0] d0,
    input logic c0, input logic w0, input logic [3:0] m0,
    input logic [15:0] a1, input logic [31:0] d1,
    input logic c1, input logic w1, input logic [3:0] m1);
    return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
  endfunction

  task automatic checkOutput(input string tag, input logic [111:0] observed,
                             input logic [111:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic applyStimulus(input logic [111:0] w);
    for (int i = 111; i >= 0; i--) begin
      scan_in = w[i];
      scan_en = 1'b1;
      @(negedge wb_clk_i);
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic shiftOut(output logic [111:0] w);
    for (int i = 111; i >= 0; i--) begin
      w[i]    = scan_out;
      scan_in = 1'b0;
      scan_en = 1'b1;
      @(negedge wb_clk_i);
    end
    scan_en = 1'b0;
  endtask

  task automatic pulseOp();
    global_csb = 1'b0;
    @(negedge wb_clk_i);
    global_csb = 1'b1;
  endtask

  task automatic pulseLoad();
    sram_load = 1'b1;
    @(negedge wb_clk_i);
    sram_load = 1'b0;
  endtask

  task automatic writeCmd(input logic [111:0] w);
    applyStimulus(w);
    pulseOp();
  endtask

  task automatic readBack(input logic [111:0] w, output logic [111:0] r);
    applyStimulus(w);
    pulseOp();
    pulseLoad();
    shiftOut(r);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wb_rst_i   = 1'b1;
    in_select  = 1'b1;
    scan_in    = 1'b0;
    scan_en    = 1'b0;
    sram_load  = 1'b0;
    global_csb = 1'b1;

    // Shifting attempted while reset is held must not move the register
    scan_in = 1'b1;
    scan_en = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checkOutput("reset_scan_out", {111'b0, scan_out}, 112'd0);
    scan_en  = 1'b0;
    scan_in  = 1'b0;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    shiftOut(obs);
    checkOutput("reset_sr_zero", obs, 112'd0);

    // Basic write of zero then read back on bank 0, port 1 idle with a marker in din1
    writeCmd(mk(4'd0, 16'd1, 32'h0, 1'b0, 1'b0, 4'hF, 16'd0, 32'hCAFEF00D, 1'b1, 1'b1, 4'h0));
    cmd = mk(4'd0, 16'd1, 32'h0, 1'b0, 1'b1, 4'hF, 16'd0, 32'hCAFEF00D, 1'b1, 1'b1, 4'h0);
    readBack(cmd, obs);
    checkOutput("bank0_basic", obs, cmd);

    // Dual-port banks: both ports write, then both ports read in one operation
    for (int i = 0; i < 5; i++) begin
      writeCmd(mk(4'(i), 16'd1, 32'(i), 1'b0, 1'b0, 4'hF,
                  16'd2, 32'(i << 3), 1'b0, 1'b0, 4'hF));
      readBack(mk(4'(i), 16'd1, 32'hA5A5A5A5, 1'b0, 1'b1, 4'hF,
                  16'd2, 32'h5A5A5A5A, 1'b0, 1'b1, 4'hF), obs);
      exp = mk(4'(i), 16'd1, 32'(i), 1'b0, 1'b1, 4'hF,
               16'd2, 32'(i << 3), 1'b0, 1'b1, 4'hF);
      checkOutput($sformatf("dp_bank%0d", i), obs, exp);
    end

    // Single-port banks: port 1 fields must be ignored
    for (int b = 8; b < 12; b++) begin
      writeCmd(mk(4'(b), 16'd1, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF,
                  16'd0, 32'h0, 1'b1, 1'b1, 4'h0));
      readBack(mk(4'(b), 16'd1, 32'h0, 1'b0, 1'b1, 4'hF,
                  16'd0, 32'h0, 1'b1, 1'b0, 4'h0), obs);
      exp = mk(4'(b), 16'd1, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF,
               16'd0, 32'h0, 1'b1, 1'b0, 4'h0);
      checkOutput($sformatf("sp_bank%0d", b), obs, exp);
    end

    // Byte mask: clear lanes 0 and 2 of an all-ones word
    writeCmd(mk(4'd1, 16'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));
    writeCmd(mk(4'd1, 16'd3, 32'h00000000, 1'b0, 1'b0, 4'b0101, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));
    readBack(mk(4'd1, 16'd3, 32'h0, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0), obs);
    checkOutput("byte_mask", obs,
                mk(4'd1, 16'd3, 32'hFF00FF00, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));

    // Same-address write collision: port 0 data must win
    writeCmd(mk(4'd2, 16'd5, 32'h11111111, 1'b0, 1'b0, 4'hF, 16'd5, 32'h22222222, 1'b0, 1'b0, 4'hF));
    readBack(mk(4'd2, 16'd5, 32'h0, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0), obs);
    checkOutput("collision_port0_wins", obs,
                mk(4'd2, 16'd5, 32'h11111111, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));

    // Port 1 reads while port 0 writes the same address: old data comes back
    cmd = mk(4'd2, 16'd5, 32'h33333333, 1'b0, 1'b0, 4'hF, 16'd5, 32'h0, 1'b0, 1'b1, 4'hF);
    readBack(cmd, obs);
    checkOutput("read_during_write_old", obs,
                mk(4'd2, 16'd5, 32'h33333333, 1'b0, 1'b0, 4'hF, 16'd5, 32'h11111111, 1'b0, 1'b1, 4'hF));
    readBack(mk(4'd2, 16'd5, 32'h0, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0), obs);
    checkOutput("read_after_write_new", obs,
                mk(4'd2, 16'd5, 32'h33333333, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));

    // Unmapped bank reads as zero
    readBack(mk(4'd6, 16'd1, 32'hA5A5A5A5, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0), obs);
    checkOutput("unmapped_sel6", obs,
                mk(4'd6, 16'd1, 32'h0, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));

    // Reset mid-shift clears scan_out without waiting for a clock edge
    scan_in = 1'b1;
    scan_en = 1'b1;
    repeat (112) @(negedge wb_clk_i);
    checkOutput("pre_reset_scan_out", {111'b0, scan_out}, {111'b0, 1'b1});
    #2 wb_rst_i = 1'b1;
    #1 checkOutput("async_reset_scan_out", {111'b0, scan_out}, 112'd0);
    @(negedge wb_clk_i);
    scan_en  = 1'b0;
    scan_in  = 1'b0;
    wb_rst_i = 1'b0;
    cmd = mk(4'hA, 16'h1234, 32'h0BADF00D, 1'b1, 1'b1, 4'h3, 16'hFFFF, 32'h13579BDF, 1'b1, 1'b0, 4'hC);
    applyStimulus(cmd);
    shiftOut(obs);
    checkOutput("resume_after_reset", obs, cmd);

    // in_select=0 must block shifting, loading and operations
    writeCmd(mk(4'd3, 16'd7, 32'hAAAA5555, 1'b0, 1'b0, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));
    cmd = mk(4'd3, 16'd7, 32'h12345678, 1'b0, 1'b0, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0);
    applyStimulus(cmd);
    in_select = 1'b0;
    for (int k = 0; k < 8; k++) begin
      scan_en    = k[0];
      scan_in    = ~k[1];
      global_csb = k[0];
      sram_load  = k[1];
      @(negedge wb_clk_i);
      global_csb = 1'b0;
      @(negedge wb_clk_i);
    end
    scan_en    = 1'b0;
    scan_in    = 1'b0;
    global_csb = 1'b1;
    sram_load  = 1'b0;
    in_select  = 1'b1;
    shiftOut(obs);
    checkOutput("insel0_sr_unchanged", obs, cmd);
    readBack(mk(4'd3, 16'd7, 32'h0, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0), obs);
    checkOutput("insel0_ram_unchanged", obs,
                mk(4'd3, 16'd7, 32'hAAAA5555, 1'b0, 1'b1, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/caravel_sram_scan.md
CARAVEL_SRAM_SCAN -- requirements
Module: caravel_sram_scan

Interface
REQ-001 Parameter DEPTH, default 16, words per SRAM bank; the address index is addr[$clog2(DEPTH)-1:0] and upper address bits are ignored.
REQ-002 Parameter SCAN_W, default 112, scan register length; it is fixed by the field map in REQ-012.
REQ-003 Port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_select, input, 1 bit: 1 = pin controls are live; 0 = scan_en, sram_load and global_csb are forced inactive (0, 0, 1).
REQ-006 Port scan_in, input, 1 bit: serial scan data in.
REQ-007 Port scan_en, input, 1 bit: shift enable.
REQ-008 Port sram_load, input, 1 bit: copy captured read data into the scan register.
REQ-009 Port global_csb, input, 1 bit: active-low SRAM operation strobe.
REQ-010 Port scan_out, output, 1 bit: always equals scan register bit [SCAN_W-1]; it is combinational from the register.

Function
REQ-011 The scan register sr[111:0] is MSB-first; on each edge with scan_en=1 and sram_load=0, sr <= {sr[110:0], scan_in}.
REQ-012 The field map, MSB to LSB, is:
- sel[111:108]
- addr0[107:92]
- din0[91:60]
- csb0[59]
- web0[58]
- wmask0[57:54]
- addr1[53:38]
- din1[37:6]
- csb1[5]
- web1[4]
- wmask1[3:0]
REQ-013 Banks sel=0..4 are dual-port 32-bit RAMs (ports 0 and 1); banks sel=8..11 are single-port 32-bit RAMs (port 0 only; port-1 fields ignored).
REQ-014 An edge with global_csb=0 performs one SRAM operation on bank sel using the current sr fields, independent of scan_en.
REQ-015 Per port, when csbN=0 and webN=0: write dinN into addrN, byte lanes enabled by wmaskN (bit k covers bits [8k+7:8k]).
REQ-016 Per port, when csbN=0 and webN=1: read addrN into doutN on that same edge, with 1-cycle latency.
REQ-017 doutN holds its value until the next read on that port.
REQ-018 Each port keeps a rd_validN flag: set by a read, cleared by sram_load.
REQ-019 On an edge with sram_load=1, din0 is replaced by dout0 if rd_valid0, and din1 by dout1 if rd_valid1; all other sr bits are unchanged.
REQ-020 sram_load has priority over scan_en.
REQ-021 sel values 5..7 and 12..15 are unmapped: writes are ignored and reads return 32'h0000_0000.
REQ-022 Dual-port write collision on the same address: port 0 data wins.
REQ-023 A read on one port while the other port writes the same address returns the old data.
REQ-024 An operation in progress is abandoned by reset; no partial-byte writes occur.

Reset
REQ-025 While wb_rst_i=1: sr=0, dout0=dout1=0, rd_valid0=rd_valid1=0, so scan_out=0.
REQ-026 RAM contents are not reset and are undefined until written.
REQ-027 Reset asserted mid-shift discards the partial scan; release resumes normal operation on the next edge.

Structure
REQ-028 A shared package caravel_sram_scan_pkg holds SCAN_W, all field MSB/LSB constants, the bank-select codes (DP_FIRST=0, DP_LAST=4, SP_FIRST=8, SP_LAST=11) and a packed scan-word struct type.
REQ-029 One sub-module, sram_bank, is a parameterised RAM (DEPTH, DUAL_PORT) with byte-masked writes and synchronous reads; it is instantiated 9 times.

Verification
REQ-030 Shift in sel=0, addr0=1, din0=0, csb0=0, web0=0, wmask0=F, port 1 idle; pulse global_csb for one cycle; then shift in sel=0, addr0=1, csb0=0, web0=1, din0=0; global_csb, then sram_load -> din0 field scans out as 32'h0000_0000 and all other bits scan out unchanged.
REQ-031 For each bank i=0..4: write i at address 1 and i<<3 at address 2, then read address 1 on port 0 and address 2 on port 1 in one operation -> all 112 scanned-out bits match {sel=i, addr0=1, din0=i, 0, 1, F, addr1=2, din1=i<<3, 0, 1, F} with no X.
REQ-032 For banks 8..11: write 32'hDEADBEEF at address 1, then read it with port 1 csb1=1 and din1=0 -> din0=DEADBEEF and din1 stays 0 in the scan-out.
REQ-033 Write 32'hFFFF_FFFF then 32'h0000_0000 with wmask0=4'b0101 -> a read returns 32'hFF00_FF00.
REQ-034 Read with sel=6 -> din0 scans out as 0; assert wb_rst_i mid-shift -> scan_out goes to 0 immediately.
REQ-035 With in_select=0, toggle scan_en and global_csb -> sr and RAM contents are unchanged.
